// File: rtl/ahb_apb_bridge_param.sv
// AHB-Lite to APB bridge: one outstanding transfer, address-decoded one-hot PSEL,
// optional ACCESS timeout, two-cycle AHB ERROR response.
module ahb_apb_bridge_param #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NSLV    = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 0
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic [1:0]      HTRANS,
  input  logic            HWRITE,
  input  logic            HREADYIN,
  input  logic [AW-1:0]   HADDR,
  input  logic [DW-1:0]   HWDATA,
  output logic [DW-1:0]   HRDATA,
  output logic            HREADYOUT,
  output logic            HRESP,
  output logic [NSLV-1:0] PSEL,
  output logic            PENABLE,
  output logic            PWRITE,
  output logic [AW-1:0]   PADDR,
  output logic [DW-1:0]   PWDATA,
  input  logic [DW-1:0]   PRDATA,
  input  logic            PREADY,
  input  logic            PSLVERR
);
  localparam int IW = $clog2((NSLV < 2) ? 2 : NSLV);

  typedef enum logic [2:0] {IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_in;
  logic [15:0]   wait_cnt;
  logic          sample, idx_bad, timed_out, apb_act;

  // NONSEQ and SEQ both carry HTRANS[1]=1; bit 0 only separates them.
  logic unused_htrans0;
  assign unused_htrans0 = HTRANS[0];

  assign idx_in    = HADDR[SEL_LSB +: IW];
  assign idx_bad   = (int'(idx_in) >= NSLV);
  assign sample    = ((state == IDLE) || (state == ERR2)) && HREADYIN && HTRANS[1];
  // Counts the current stalled cycle too, so TIMEOUT=N allows exactly N ACCESS cycles.
  assign timed_out = (TIMEOUT != 0) && !PREADY &&
                     (({1'b0, wait_cnt} + 17'd1) == 17'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ERR2: begin
        if (sample) begin
          if (idx_bad)     state_nxt = ERR1;
          else if (HWRITE) state_nxt = WWAIT;
          else             state_nxt = SETUP;
        end else begin
          state_nxt = IDLE;
        end
      end
      WWAIT:  state_nxt = SETUP;
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (PREADY)         state_nxt = PSLVERR ? ERR1 : IDLE;
        else if (timed_out) state_nxt = ERR1;
      end
      ERR1:    state_nxt = ERR2;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= IDLE;
      idx      <= '0;
      PADDR    <= '0;
      PWRITE   <= 1'b0;
      PWDATA   <= '0;
      HRDATA   <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (sample) begin
        PADDR  <= HADDR;
        PWRITE <= HWRITE;
        idx    <= idx_in;
      end
      if (state == WWAIT)
        PWDATA <= HWDATA;
      if ((state == ACCESS) && PREADY && !PSLVERR && !PWRITE)
        HRDATA <= PRDATA;
      if (state == SETUP)
        wait_cnt <= '0;
      else if ((state == ACCESS) && !PREADY)
        wait_cnt <= wait_cnt + 16'd1;
    end
  end

  assign apb_act   = (state == SETUP) || (state == ACCESS);
  assign PENABLE   = (state == ACCESS);
  assign HREADYOUT = (state == IDLE) || (state == ERR2);
  assign HRESP     = (state == ERR1) || (state == ERR2);

  for (genvar s = 0; s < NSLV; s++) begin : g_psel
    assign PSEL[s] = apb_act && (idx == IW'(s));
  end
endmodule

// File: tb/tb_ahb_apb_bridge_param.sv
// Bench for ahb_apb_bridge_param: transaction-level phase model feeding a per-cycle
// comparator, plus literal cycle-exact expectations taken from a recorded output trace.
module tb_ahb_apb_bridge_param;
  localparam int AW = 32, DW = 32, NSLV = 5, SEL_LSB = 12, TIMEOUT = 4;
  localparam int IW = 3;
  localparam int TR = 1024;

  logic            HCLK, HRESET;
  logic [1:0]      HTRANS;
  logic            HWRITE, HREADYIN;
  logic [AW-1:0]   HADDR;
  logic [DW-1:0]   HWDATA, HRDATA;
  logic            HREADYOUT, HRESP;
  logic [NSLV-1:0] PSEL;
  logic            PENABLE, PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA, PRDATA;
  logic            PREADY, PSLVERR;

  ahb_apb_bridge_param #(.AW(AW), .DW(DW), .NSLV(NSLV), .SEL_LSB(SEL_LSB), .TIMEOUT(TIMEOUT)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADYIN(HREADYIN),
    .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR));

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Expected bus view for one cycle; acc/last steer the PREADY the bench drives.
  typedef struct {
    logic            hready, hresp, pen, pwrite, acc, last;
    logic [NSLV-1:0] psel;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata, hrdata;
  } ph_t;

  ph_t exp_q[$];
  ph_t e;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata, m_hrdata;
  logic          m_pwrite;
  int n_chk = 0, n_err = 0, cyc = 0;
  logic chk_en = 1'b0;

  logic            t_hready [TR], t_hresp [TR], t_pen [TR];
  logic [NSLV-1:0] t_psel [TR];
  logic [DW-1:0]   t_hrdata [TR], t_pwdata [TR];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, expv);
    end
  endtask

  function automatic ph_t idle_ph();
    ph_t p;
    p.hready = 1'b1; p.hresp = 1'b0; p.pen = 1'b0; p.acc = 1'b0; p.last = 1'b0;
    p.psel = '0; p.pwrite = m_pwrite; p.paddr = m_paddr;
    p.pwdata = m_pwdata; p.hrdata = m_hrdata;
    return p;
  endfunction

  always @(posedge HCLK) cyc <= cyc + 1;

  always @(negedge HCLK) begin
    if (cyc < TR) begin
      t_hready[cyc] <= HREADYOUT; t_hresp[cyc] <= HRESP; t_pen[cyc] <= PENABLE;
      t_psel[cyc] <= PSEL; t_hrdata[cyc] <= HRDATA; t_pwdata[cyc] <= PWDATA;
    end
    if (chk_en && !HRESET) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = idle_ph();
      chk("hreadyout", 64'(HREADYOUT), 64'(e.hready));
      chk("hresp",     64'(HRESP),     64'(e.hresp));
      chk("psel",      64'(PSEL),      64'(e.psel));
      chk("penable",   64'(PENABLE),   64'(e.pen));
      chk("pwrite",    64'(PWRITE),    64'(e.pwrite));
      chk("paddr",     64'(PADDR),     64'(e.paddr));
      chk("pwdata",    64'(PWDATA),    64'(e.pwdata));
      chk("hrdata",    64'(HRDATA),    64'(e.hrdata));
    end
  end

  // APB inputs outside ACCESS are deliberately hostile; the bridge must ignore them.
  task automatic noise();
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = DW'($urandom);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      HTRANS = 2'b00; HREADYIN = 1'b1; noise();
      @(posedge HCLK); #1;
    end
  endtask

  // One AHB transfer; n returns the address-phase cycle. b2b returns at the start of
  // ERR2 so the next address phase overlaps it.
  task automatic xfer(input logic [1:0] tr, input logic [AW-1:0] addr, input logic wr,
                      input logic [DW-1:0] wdata, input int waits, input logic slverr,
                      input logic [DW-1:0] rdata, input logic b2b, output int n);
    ph_t ph[$];
    ph_t p;
    int ix, nacc;
    logic to;
    n = cyc;
    HTRANS = tr; HREADYIN = 1'b1; HADDR = addr; HWRITE = wr; HWDATA = ~wdata; noise();
    @(posedge HCLK); #1;
    HTRANS = 2'b00; HWRITE = 1'($urandom); HADDR = AW'($urandom); HWDATA = wdata;
    m_paddr = addr; m_pwrite = wr;
    ix = int'(addr[SEL_LSB +: IW]);
    p = idle_ph(); p.hready = 1'b0;
    if (ix >= NSLV) begin
      p.hresp = 1'b1; ph.push_back(p);
      p.hready = 1'b1; ph.push_back(p);
    end else begin
      if (wr) begin ph.push_back(p); m_pwdata = wdata; p.pwdata = wdata; end
      p.psel = '0; p.psel[ix] = 1'b1;
      ph.push_back(p);
      to = (TIMEOUT != 0) && (waits >= TIMEOUT);
      nacc = to ? TIMEOUT : waits + 1;
      p.pen = 1'b1; p.acc = 1'b1;
      for (int i = 0; i < nacc; i++) begin
        p.last = !to && (i == nacc - 1);
        ph.push_back(p);
      end
      p = idle_ph();
      if (to || slverr) begin
        p.hready = 1'b0; p.hresp = 1'b1; ph.push_back(p);
        p.hready = 1'b1; ph.push_back(p);
      end else if (!wr) begin
        m_hrdata = rdata;
      end
    end
    foreach (ph[i]) exp_q.push_back(ph[i]);
    foreach (ph[i]) begin
      if (b2b && (i == ph.size() - 1)) return;
      if (i > 0) HWDATA = DW'($urandom);
      if (ph[i].acc) begin
        PREADY = ph[i].last; PSLVERR = ph[i].last & slverr;
        PRDATA = ph[i].last ? rdata : DW'($urandom);
      end else begin
        noise();
      end
      @(posedge HCLK); #1;
    end
    noise();
  endtask

  task automatic reset_model();
    exp_q.delete();
    m_paddr = '0; m_pwdata = '0; m_hrdata = '0; m_pwrite = 1'b0;
  endtask

  task automatic chk_reset_pins(input string tag);
    chk({tag, "_psel"},   64'(PSEL), 64'(0));
    chk({tag, "_pen"},    64'(PENABLE), 64'(0));
    chk({tag, "_hready"}, 64'(HREADYOUT), 64'(1));
    chk({tag, "_hresp"},  64'(HRESP), 64'(0));
    chk({tag, "_paddr"},  64'(PADDR), 64'(0));
    chk({tag, "_hrdata"}, 64'(HRDATA), 64'(0));
    chk({tag, "_pwdata"}, 64'(PWDATA), 64'(0));
    chk({tag, "_pwrite"}, 64'(PWRITE), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2;
    HRESET = 1'b1; HTRANS = 2'b00; HWRITE = 1'b0; HREADYIN = 1'b1;
    HADDR = '0; HWDATA = '0; noise();
    reset_model();
    #12 chk_reset_pins("rst0");
    @(posedge HCLK); #1;
    HRESET = 1'b0; chk_en = 1'b1;
    idle(2);

    // Read idx 1, no wait states
    xfer(2'b10, 32'h0000_1004, 1'b0, '0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, n);
    idle(2);
    chk("rd_psel_n1", 64'(t_psel[n+1]), 64'(5'b00010));
    chk("rd_psel_n2", 64'(t_psel[n+2]), 64'(5'b00010));
    chk("rd_pen_n1",  64'(t_pen[n+1]),  64'(0));
    chk("rd_pen_n2",  64'(t_pen[n+2]),  64'(1));
    chk("rd_hrdy_n2", 64'(t_hready[n+2]), 64'(0));
    chk("rd_hrdy_n3", 64'(t_hready[n+3]), 64'(1));
    chk("rd_data_n3", 64'(t_hrdata[n+3]), 64'(32'hDEAD_BEEF));

    // Write idx 3, three wait states
    xfer(2'b10, 32'h0000_3008, 1'b1, 32'h1234_5678, 3, 1'b0, 32'hBAD0_BAD0, 1'b0, n);
    idle(2);
    chk("wr_pwdata_n2", 64'(t_pwdata[n+2]), 64'(32'h1234_5678));
    chk("wr_psel_n2",   64'(t_psel[n+2]), 64'(5'b01000));
    chk("wr_pen_n2",    64'(t_pen[n+2]), 64'(0));
    chk("wr_pen_n3",    64'(t_pen[n+3]), 64'(1));
    chk("wr_pen_n6",    64'(t_pen[n+6]), 64'(1));
    chk("wr_hrdy_n6",   64'(t_hready[n+6]), 64'(0));
    chk("wr_hrdy_n7",   64'(t_hready[n+7]), 64'(1));
    chk("wr_hrdata",    64'(t_hrdata[n+7]), 64'(32'hDEAD_BEEF));

    // Not-ready and BUSY address phases must be ignored
    HTRANS = 2'b10; HREADYIN = 1'b0; HADDR = 32'h0000_2000; HWRITE = 1'b1;
    @(posedge HCLK); #1;
    HTRANS = 2'b01; HREADYIN = 1'b1;
    @(posedge HCLK); #1;
    idle(1);

    // Slave index beyond NSLV: error without APB activity
    xfer(2'b10, 32'h0000_5000, 1'b0, '0, 0, 1'b0, 32'h1111_1111, 1'b0, n);
    idle(2);
    chk("bad_psel_n1", 64'(t_psel[n+1]), 64'(0));
    chk("bad_hresp_n1", 64'(t_hresp[n+1]), 64'(1));
    chk("bad_hrdy_n1", 64'(t_hready[n+1]), 64'(0));
    chk("bad_hresp_n2", 64'(t_hresp[n+2]), 64'(1));
    chk("bad_hrdy_n2", 64'(t_hready[n+2]), 64'(1));
    chk("bad_hresp_n3", 64'(t_hresp[n+3]), 64'(0));
    xfer(2'b10, 32'h0000_7ABC, 1'b1, 32'hCAFE_0001, 0, 1'b0, '0, 1'b0, n);
    idle(1);

    // Highest legal slave index
    xfer(2'b10, 32'h0000_4FFC, 1'b0, '0, 2, 1'b0, 32'hA5A5_5A5A, 1'b0, n);
    idle(2);
    chk("top_psel_n1", 64'(t_psel[n+1]), 64'(5'b10000));

    // Write with PSLVERR, next read sampled during ERR2
    xfer(2'b10, 32'h0000_0010, 1'b1, 32'h0F0F_F0F0, 1, 1'b1, '0, 1'b1, n);
    xfer(2'b10, 32'h0000_2020, 1'b0, '0, 0, 1'b0, 32'h0BAD_F00D, 1'b0, n2);
    idle(2);
    chk("b2b_err2_cyc",   64'(n2), 64'(n + 6));
    chk("b2b_err1_hresp", 64'(t_hresp[n+5]), 64'(1));
    chk("b2b_err1_hrdy",  64'(t_hready[n+5]), 64'(0));
    chk("b2b_err2_hrdy",  64'(t_hready[n+6]), 64'(1));
    chk("b2b_setup_psel", 64'(t_psel[n2+1]), 64'(5'b00100));
    chk("b2b_setup_pen",  64'(t_pen[n2+1]), 64'(0));
    chk("b2b_rdata",      64'(t_hrdata[n2+3]), 64'(32'h0BAD_F00D));

    // Read with PSLVERR keeps old HRDATA
    xfer(2'b10, 32'h0000_1000, 1'b0, '0, 0, 1'b1, 32'h7777_7777, 1'b0, n);
    idle(1);

    // Timeout after four stalled ACCESS cycles
    xfer(2'b10, 32'h0000_2000, 1'b0, '0, 10, 1'b0, 32'h5555_5555, 1'b0, n);
    idle(2);
    chk("to_pen_n5",   64'(t_pen[n+5]), 64'(1));
    chk("to_psel_n6",  64'(t_psel[n+6]), 64'(0));
    chk("to_hresp_n6", 64'(t_hresp[n+6]), 64'(1));
    chk("to_hrdy_n7",  64'(t_hready[n+7]), 64'(1));
    chk("to_hresp_n8", 64'(t_hresp[n+8]), 64'(0));
    chk("to_hrdata",   64'(t_hrdata[n+8]), 64'(32'h0BAD_F00D));

    // SEQ transfer is sampled like NONSEQ
    xfer(2'b11, 32'h0000_1100, 1'b1, 32'h0000_BEEF, 0, 1'b0, '0, 1'b0, n);
    idle(1);

    // Asynchronous reset while in ACCESS
    chk_en = 1'b0;
    HTRANS = 2'b10; HADDR = 32'h0000_1000; HWRITE = 1'b0;
    @(posedge HCLK); #1;
    HTRANS = 2'b00; PREADY = 1'b0; PSLVERR = 1'b0;
    @(posedge HCLK); #1;
    chk("mid_pen_pre", 64'(PENABLE), 64'(1));
    #2 HRESET = 1'b1;
    #1 chk_reset_pins("rst_mid");
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    HRESET = 1'b0; reset_model(); chk_en = 1'b1;
    xfer(2'b10, 32'h0000_0008, 1'b0, '0, 0, 1'b0, 32'h0000_00AA, 1'b0, n);
    idle(3);
    chk("post_rst_psel", 64'(t_psel[n+1]), 64'(5'b00001));
    chk("post_rst_data", 64'(t_hrdata[n+3]), 64'(32'h0000_00AA));
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
